// File: rtl/key_expansion_seq_if.sv
// key_expansion_seq_if: bundles the key-expansion handshake and schedule bus.
//   start    request expansion of key (driven by master)
//   key      [0:127] cipher key, bit 0 = MSB of byte 0 (driven by master)
//   busy     expansion in progress (driven by slave)
//   valid    words holds a complete schedule (driven by slave)
//   words    [0:32*NWORDS-1] schedule, word i at bits [32i:32i+31] (driven by slave)
//   rk_valid [0:ROUNDS] per-round-key ready flags, only with KEYEXP_ROUND_VALID_EN
interface key_expansion_seq_if #(parameter int ROUNDS = 10);
   localparam int NWORDS = 4 * (ROUNDS + 1);
   logic                    start;
   logic [0:127]            key;
   logic                    busy;
   logic                    valid;
   logic [0:32*NWORDS-1]    words;
`ifdef KEYEXP_ROUND_VALID_EN
   logic [0:ROUNDS]         rk_valid;
   modport master (output start, key, input busy, valid, words, rk_valid);
   modport slave  (input start, key, output busy, valid, words, rk_valid);
`else
   modport master (output start, key, input busy, valid, words);
   modport slave  (input start, key, output busy, valid, words);
`endif
endinterface

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128 key expansion, one 32-bit schedule word per clock.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    key_expansion_seq_if.slave: start/key in; busy/valid/words (and rk_valid) out
// Optional feature macro: KEYEXP_ROUND_VALID_EN adds bus.rk_valid, a per-round-key ready vector.
module key_expansion_seq #(
   parameter int ROUNDS = 10
) (
   input logic               clk,
   input logic               rst_n,
   key_expansion_seq_if.slave bus
);
   localparam int NWORDS = 4 * (ROUNDS + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nx;
   logic [31:0] w [0:NWORDS-1];
   logic [5:0]  idx;
   logic [7:0]  rcon;
   logic        accept, last;
   logic [31:0] prev, sub, temp;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Byte S-box: multiplicative inverse as a^254 (0 maps to 0), then the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] s, r;
      s = gmul(a, a);
      r = s;
      for (int i = 0; i < 6; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      if (state == IDLE && bus.start) begin
         accept   = 1'b1;
         state_nx = RUN;
      end else if (state == RUN && idx == 6'd43) begin
         last     = 1'b1;
         state_nx = IDLE;
      end
   end

   assign prev = w[idx - 6'd1];
   assign sub  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])};
   assign temp = (idx[1:0] == 2'd0) ? (sub ^ {rcon, 24'h0}) : prev;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) w[i] <= '0;
         idx       <= '0;
         rcon      <= 8'h01;
         bus.busy  <= 1'b0;
         bus.valid <= 1'b0;
`ifdef KEYEXP_ROUND_VALID_EN
         bus.rk_valid <= '0;
`endif
      end else if (accept) begin
         for (int i = 0; i < NWORDS; i++) w[i] <= (i < 4) ? bus.key[32*i +: 32] : 32'h0;
         idx       <= 6'd4;
         rcon      <= 8'h01;
         bus.busy  <= 1'b1;
         bus.valid <= 1'b0;
`ifdef KEYEXP_ROUND_VALID_EN
         bus.rk_valid <= {1'b1, {ROUNDS{1'b0}}};
`endif
      end else if (state == RUN) begin
         w[idx] <= w[idx - 6'd4] ^ temp;
         idx    <= last ? idx : idx + 6'd1;
         if (idx[1:0] == 2'd0) rcon <= xt(rcon);
         if (last) begin
            bus.busy  <= 1'b0;
            bus.valid <= 1'b1;
         end
`ifdef KEYEXP_ROUND_VALID_EN
         // Writing word 4r+3 completes round key r.
         if (idx[1:0] == 2'd3) bus.rk_valid[idx[5:2]] <= 1'b1;
`endif
      end
   end

   for (genvar g = 0; g < NWORDS; g++) begin : g_words
      assign bus.words[32*g +: 32] = w[g];
   end
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: scoreboard bench for key_expansion_seq; expected schedules are built
// from a table-driven reference model and queued on every accepted start.
module tb_key_expansion_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [0:1407] exp_q [$];
   logic [0:1407] last_exp;
   logic [127:0]  k1, k2;

   always #5 clk = ~clk;

   key_expansion_seq_if bus ();
   key_expansion_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   logic [0:2047] sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_tab[int'(x)*8 +: 8];
   endfunction

   function automatic logic [0:1407] model(input logic [0:127] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [0:1407] r;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_words(input string tag, input logic [0:1407] expv);
      for (int c = 0; c < 11; c++)
         chk($sformatf("%s_chunk%0d", tag, c), bus.words[128*c +: 128], expv[128*c +: 128]);
   endtask

`ifdef KEYEXP_ROUND_VALID_EN
   task automatic chk_rk(input string tag, input int n);
      logic [0:10] e;
      for (int r = 0; r < 11; r++) e[r] = (r <= n / 4);
      chk($sformatf("%s_rk%0d", tag, n), 128'(bus.rk_valid), 128'(e));
   endtask
`endif

   // Drive start with key at a negedge; returns at the negedge after the accepting edge.
   task automatic accept(input string tag, input logic [127:0] k, input bit hold);
      bus.key   = k;
      bus.start = 1'b1;
      exp_q.push_back(model(k));
      @(negedge clk);
      chk({tag, "_busy_on"}, 128'(bus.busy), 128'(1));
      chk({tag, "_valid_off"}, 128'(bus.valid), 128'(0));
      chk({tag, "_tail_zero"}, bus.words[1280 +: 128], 128'h0);
      if (!hold) bus.start = 1'b0;
   endtask

   // Called at the negedge after the accepting edge; valid is due 40 edges later.
   task automatic wait_done(input string tag);
      int n = 0;
      logic [0:1407] e;
      e = exp_q[0];
      while (bus.valid !== 1'b1 && n < 60) begin
`ifdef KEYEXP_ROUND_VALID_EN
         chk_rk(tag, n);
`endif
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_w4"}, 128'(bus.words[128 +: 32]), 128'(e[128 +: 32]));
      end
`ifdef KEYEXP_ROUND_VALID_EN
      chk_rk(tag, n);
`endif
      chk({tag, "_latency"}, 128'(n), 128'(40));
      chk({tag, "_busy_off"}, 128'(bus.busy), 128'(0));
      last_exp = exp_q.pop_front();
      chk_words(tag, last_exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.key   = 128'hffeeddccbbaa99887766554433221100;
      repeat (2) @(negedge clk);
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_valid", 128'(bus.valid), 128'(0));
      chk_words("rst", '0);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("idle_busy", 128'(bus.busy), 128'(0));

      accept("a1", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
      wait_done("a1");
      chk("a1_fips_w4", 128'(bus.words[128 +: 32]), 128'ha0fafe17);
      chk("a1_fips_last", bus.words[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      accept("c1", 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
      wait_done("c1");
      chk("c1_fips_last", bus.words[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      repeat (3) @(negedge clk);
      chk("hold_busy", 128'(bus.busy), 128'(0));
      chk("hold_valid", 128'(bus.valid), 128'(1));
      chk_words("hold", last_exp);

      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      accept("run_ign", k1, 1'b1);
      bus.key = k2;
      wait_done("run_ign");
      exp_q.push_back(model(k2));
      @(negedge clk);
      chk("reacc_busy", 128'(bus.busy), 128'(1));
      chk("reacc_valid_drop", 128'(bus.valid), 128'(0));
      bus.start = 1'b0;
      wait_done("reacc");
      repeat (2) @(negedge clk);
      chk("one_exp_busy", 128'(bus.busy), 128'(0));

      accept("mid_rst", {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      void'(exp_q.pop_front());
      chk("mid_rst_busy", 128'(bus.busy), 128'(0));
      chk("mid_rst_valid", 128'(bus.valid), 128'(0));
      chk_words("mid_rst", '0);
`ifdef KEYEXP_ROUND_VALID_EN
      chk("mid_rst_rk", 128'(bus.rk_valid), 128'(0));
`endif
      @(negedge clk);
      accept("post_rst", 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
      wait_done("post_rst");

      for (int t = 0; t < 2; t++) begin
         accept($sformatf("rnd%0d", t), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
         wait_done($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
